regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
Parametrised successor to the single-cycle register file, for the pipelined core. It provides:
- Configurable width and depth.
- Two synchronous read ports with write-to-read bypass.
- A hardwired-zero register 0.
- A hardware clear sequencer that zeroes the array after reset.
- A per-register busy scoreboard, so the issue stage can detect RAW hazards on pending writebacks.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; DEPTH = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never busy; 0 = register 0 behaves like any other register

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
readReg1  in  ADDR_W  read port 1 index
readReg2  in  ADDR_W  read port 2 index
readData1  out  DATA_W  read port 1 data, registered
readData2  out  DATA_W  read port 2 data, registered
writeReg  in  ADDR_W  write index
writeData  in  DATA_W  write data
write  in  1  write enable; also clears the busy bit of writeReg
reserve  in  1  mark reserveReg busy (instruction issued)
reserveReg  in  ADDR_W  index to reserve
busy1  out  1  busy bit of readReg1, combinational
busy2  out  1  busy bit of readReg2, combinational
ready  out  1  high when the clear sweep is finished and ports are live

Behaviour:
- Reset is asynchronous and active-low.
- While rst_n=0:
  - FSM=CLEAR, clear counter=0, ready=0.
  - readData1/2=0, busy vector all 0.
  - The array is not reset directly.
- FSM states:
  - CLEAR: each cycle writes 0 to entry[counter], then counter+1. When counter==DEPTH-1 the final entry is written and the FSM goes to RUN. The sweep takes exactly DEPTH cycles after rst_n rises. ready rises on the edge that enters RUN.
  - RUN: normal operation. It is terminal until the next reset.
- During CLEAR:
  - write and reserve are ignored.
  - readData1/2 are held at 0.
  - busy1/2 read 0.
- Reset asserted mid-sweep or mid-operation restarts CLEAR from counter 0.
- Writes (RUN): on posedge with write=1, entry[writeReg] <= writeData.
  - If ZERO_REG=1 and writeReg==0, the write is dropped.
- Reads (RUN): on posedge, readDataN <= entry[readRegN]. Latency is 1 cycle.
- Bypass: if write=1 in the same cycle and writeReg==readRegN (and the write is not dropped), readDataN <= writeData (write-first).
- Zero register: if ZERO_REG=1 and readRegN==0, readDataN <= 0 regardless of bypass.
- Scoreboard (RUN), on posedge:
  - write=1 clears busy[writeReg].
  - reserve=1 sets busy[reserveReg].
  - Same index on both in one cycle: set wins, because the new producer supersedes the retiring one.
  - Writes to different indices are independent.
  - reserve of register 0 with ZERO_REG=1 is ignored.
  - A write to a non-busy register is legal and leaves it non-busy.
- Busy outputs: busyN = busy[readRegN], combinational from current state, with no bypass of same-cycle write/reserve. A write landing this cycle is covered by the data bypass, so the issue stage stalls at most one extra cycle.
- No X may propagate from the uninitialised array to the outputs after ready=1.

Test Plan:
1. Reset and sweep:
   - Stimulus: rst_n low for 3 cycles, then high; default params; write=1 driven throughout.
   - Required response: ready=0 for exactly 32 cycles, then 1. All 32 entries read back 0, and the writes issued during CLEAR have no effect.
2. Read latency and bypass:
   - Stimulus: write reg5=0xDEADBEEF with readReg1=5 in the same cycle; next cycle readReg2=5.
   - Required response: readData1=0xDEADBEEF on the following edge via bypass, and readData2=0xDEADBEEF one cycle later from the array.
3. Zero register:
   - Stimulus: write reg0=0xFFFFFFFF while readReg1=0; then reserve reg0.
   - Required response: readData1 stays 0 and busy1 stays 0.
   - Repeat with ZERO_REG=0: readData1=0xFFFFFFFF and busy1=1 after the reserve.
4. Scoreboard:
   - Stimulus: reserve reg7, then set readReg1=7.
   - Required response: busy1=1. After write reg7=0x12 it shows busy1=0 and readData1=0x12.
   - Stimulus: reserve reg9 and write reg9 in the same cycle.
   - Required response: busy[9]=1 afterwards.
5. Reset mid-operation:
   - Stimulus: write reg3=0xA5A5A5A5, reserve reg4, pulse rst_n low mid-cycle, then let the sweep finish.
   - Required response: outputs go to 0 asynchronously, the full 32-cycle sweep repeats, then reg3 reads 0 and busy on reg4 reads 0.
6. Parametrisation:
   - Stimulus: DATA_W=16, ADDR_W=3; write reg7=0xBEEF, then reg0 wrap-adjacent reg1=0x0001.
   - Required response: the sweep lasts 8 cycles, and both values read back correctly with no aliasing.

Source files
------------

// File: rtl/regfile_param_if.sv
// Port bundle of the register file: two read ports, one write port and the
// busy scoreboard used by the issue stage.
interface regfile_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] readReg1;
    logic [ADDR_W-1:0] readReg2;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              write;
    logic              reserve;
    logic [ADDR_W-1:0] reserveReg;
    logic              busy1;
    logic              busy2;
    logic              ready;

    modport master (
        output readReg1, readReg2, writeReg, writeData, write, reserve, reserveReg,
        input  readData1, readData2, busy1, busy2, ready
    );

    modport slave (
        input  readReg1, readReg2, writeReg, writeData, write, reserve, reserveReg,
        output readData1, readData2, busy1, busy2, ready
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2R/1W register file with write-first bypass, optional hardwired
// zero register, post-reset clear sweep and a per-register busy scoreboard.
module regfile_param #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    regfile_param_if.slave bus
);
    localparam int unsigned       DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              run;
    logic              wr_ok;
    logic              rsv_ok;

    assign run    = (state_q == ST_RUN);
    assign wr_ok  = run && bus.write   && !((ZERO_REG != 0) && (bus.writeReg   == '0));
    assign rsv_ok = run && bus.reserve && !((ZERO_REG != 0) && (bus.reserveReg == '0));

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        rdata1_d  = '0;
        rdata2_d  = '0;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        unique case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) state_d = ST_RUN;
            end
            ST_RUN: begin
                mem_we    = wr_ok;
                mem_waddr = bus.writeReg;
                mem_wdata = bus.writeData;
                if (wr_ok)  busy_d[bus.writeReg]   = 1'b0;
                // Reserve is applied last: a new producer supersedes the retiring one.
                if (rsv_ok) busy_d[bus.reserveReg] = 1'b1;

                if ((ZERO_REG != 0) && (bus.readReg1 == '0)) rdata1_d = '0;
                else if (wr_ok && (bus.writeReg == bus.readReg1)) rdata1_d = bus.writeData;
                else rdata1_d = mem_q[bus.readReg1];

                if ((ZERO_REG != 0) && (bus.readReg2 == '0)) rdata2_d = '0;
                else if (wr_ok && (bus.writeReg == bus.readReg2)) rdata2_d = bus.writeData;
                else rdata2_d = mem_q[bus.readReg2];
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            busy_q   <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

    // NOTE: the array has no reset port; the CLEAR sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus.readData1 = rdata1_q;
    assign bus.readData2 = rdata2_q;
    assign bus.busy1     = run && busy_q[bus.readReg1];
    assign bus.busy2     = run && busy_q[bus.readReg2];
    assign bus.ready     = run;
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: default, ZERO_REG=0 and 16x8 instances driven from
// vector tables, with expectations queued at drive time and popped after the edge.
module tb_regfile_param;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
    regfile_param_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    regfile_param_if #(.DATA_W(16), .ADDR_W(3)) bus2 ();

    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        int          dut;
        string       name;
        logic [4:0]  r1, r2, wreg, rreg;
        logic        wr, rsv;
        logic [31:0] wdata;
        logic [31:0] e_d1, e_d2;
        logic        e_b1, e_b2;
    } vec_t;

    typedef struct {
        int          dut;
        string       name;
        logic [31:0] e_d1, e_d2;
        logic        e_b1, e_b2;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs_a[$];
    vec_t vecs_b[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int dut, input string name,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic wr, input logic [4:0] wreg, input logic [31:0] wdata,
                                input logic rsv, input logic [4:0] rreg,
                                input logic [31:0] e_d1, input logic [31:0] e_d2,
                                input logic e_b1, input logic e_b2);
        vec_t v;
        v.dut = dut; v.name = name; v.r1 = r1; v.r2 = r2;
        v.wr = wr; v.wreg = wreg; v.wdata = wdata; v.rsv = rsv; v.rreg = rreg;
        v.e_d1 = e_d1; v.e_d2 = e_d2; v.e_b1 = e_b1; v.e_b2 = e_b2;
        return v;
    endfunction

    task automatic idle_all();
        bus0.readReg1 = '0; bus0.readReg2 = '0; bus0.writeReg = '0; bus0.writeData = '0;
        bus0.write = 1'b0; bus0.reserve = 1'b0; bus0.reserveReg = '0;
        bus1.readReg1 = '0; bus1.readReg2 = '0; bus1.writeReg = '0; bus1.writeData = '0;
        bus1.write = 1'b0; bus1.reserve = 1'b0; bus1.reserveReg = '0;
        bus2.readReg1 = '0; bus2.readReg2 = '0; bus2.writeReg = '0; bus2.writeData = '0;
        bus2.write = 1'b0; bus2.reserve = 1'b0; bus2.reserveReg = '0;
    endtask

    task automatic drive(input vec_t v);
        idle_all();
        case (v.dut)
            0: begin
                bus0.readReg1 = v.r1; bus0.readReg2 = v.r2; bus0.write = v.wr;
                bus0.writeReg = v.wreg; bus0.writeData = v.wdata;
                bus0.reserve = v.rsv; bus0.reserveReg = v.rreg;
            end
            1: begin
                bus1.readReg1 = v.r1; bus1.readReg2 = v.r2; bus1.write = v.wr;
                bus1.writeReg = v.wreg; bus1.writeData = v.wdata;
                bus1.reserve = v.rsv; bus1.reserveReg = v.rreg;
            end
            default: begin
                bus2.readReg1 = v.r1[2:0]; bus2.readReg2 = v.r2[2:0]; bus2.write = v.wr;
                bus2.writeReg = v.wreg[2:0]; bus2.writeData = v.wdata[15:0];
                bus2.reserve = v.rsv; bus2.reserveReg = v.rreg[2:0];
            end
        endcase
    endtask

    task automatic sample(input int dut, output logic [31:0] d1, output logic [31:0] d2,
                          output logic b1, output logic b2);
        case (dut)
            0:       begin d1 = bus0.readData1; d2 = bus0.readData2; b1 = bus0.busy1; b2 = bus0.busy2; end
            1:       begin d1 = bus1.readData1; d2 = bus1.readData2; b1 = bus1.busy1; b2 = bus1.busy2; end
            default: begin d1 = 32'(bus2.readData1); d2 = 32'(bus2.readData2); b1 = bus2.busy1; b2 = bus2.busy2; end
        endcase
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [31:0] d1, d2;
        logic        b1, b2;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb_q.pop_front();
            sample(e.dut, d1, d2, b1, b2);
            check({e.name, ".rd1"}, d1, e.e_d1);
            check({e.name, ".rd2"}, d2, e.e_d2);
            check({e.name, ".busy1"}, {31'b0, b1}, {31'b0, e.e_b1});
            check({e.name, ".busy2"}, {31'b0, b2}, {31'b0, e.e_b2});
        end
    endtask

    // Called at a negedge (or inside the low phase); returns at a negedge.
    task automatic apply_vec(input vec_t v);
        exp_t e;
        drive(v);
        e.dut = v.dut; e.name = v.name;
        e.e_d1 = v.e_d1; e.e_d2 = v.e_d2; e.e_b1 = v.e_b1; e.e_b2 = v.e_b2;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        pop_check();
    endtask

    // Counts edges after reset release until each instance reports ready.
    task automatic sweep_and_measure(input string tag, input bit hammer);
        int r0 = 0, r1 = 0, r2 = 0;
        bit leak = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            if (hammer && r0 == 0) begin
                bus0.write = 1'b1; bus0.writeReg = 5'(k); bus0.writeData = 32'hFFFF_FFFF;
                bus0.reserve = 1'b1; bus0.reserveReg = 5'(k);
                bus0.readReg1 = 5'(k); bus0.readReg2 = 5'(k + 1);
            end else begin
                idle_all();
            end
            @(posedge clk);
            @(negedge clk);
            if (bus0.ready !== 1'b1 && (bus0.readData1 !== '0 || bus0.readData2 !== '0 ||
                                         bus0.busy1 !== 1'b0 || bus0.busy2 !== 1'b0)) leak = 1'b1;
            if (bus0.ready === 1'b1 && r0 == 0) r0 = k;
            if (bus1.ready === 1'b1 && r1 == 0) r1 = k;
            if (bus2.ready === 1'b1 && r2 == 0) r2 = k;
            if (r0 != 0 && r1 != 0 && r2 != 0) break;
        end
        idle_all();
        check({tag, ".sweep_cycles_dut0"}, 32'(r0), 32'd32);
        check({tag, ".sweep_cycles_dut1"}, 32'(r1), 32'd32);
        check({tag, ".sweep_cycles_dut2"}, 32'(r2), 32'd8);
        check({tag, ".clear_outputs_quiet"}, {31'b0, leak}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs_a.push_back(mk(0, "bypass",    5,  0, 1,  5, 32'hDEAD_BEEF, 0,  0, 32'hDEAD_BEEF, 32'h0,         0, 0));
        vecs_a.push_back(mk(0, "array_rd",  5,  5, 0,  0, 32'h0,         0,  0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0));
        vecs_a.push_back(mk(0, "zero_wr",   0,  5, 1,  0, 32'hFFFF_FFFF, 0,  0, 32'h0,         32'hDEAD_BEEF, 0, 0));
        vecs_a.push_back(mk(0, "zero_rsv",  0,  5, 0,  0, 32'h0,         1,  0, 32'h0,         32'hDEAD_BEEF, 0, 0));
        vecs_a.push_back(mk(0, "zero_hold", 0,  0, 0,  0, 32'h0,         0,  0, 32'h0,         32'h0,         0, 0));
        vecs_a.push_back(mk(0, "rsv7",      7,  0, 0,  0, 32'h0,         1,  7, 32'h0,         32'h0,         1, 0));
        vecs_a.push_back(mk(0, "wr7",       7,  0, 1,  7, 32'h12,        0,  0, 32'h12,        32'h0,         0, 0));
        vecs_a.push_back(mk(0, "set_wins9", 9,  7, 1,  9, 32'h99,        1,  9, 32'h99,        32'h12,        1, 0));
        vecs_a.push_back(mk(0, "hold9",     9,  7, 0,  0, 32'h0,         0,  0, 32'h99,        32'h12,        1, 0));
        vecs_a.push_back(mk(0, "indep",     9, 10, 1,  9, 32'h100,       1, 10, 32'h100,       32'h0,         0, 1));
        vecs_a.push_back(mk(0, "nonbusy",  11, 10, 1, 11, 32'h5,         0,  0, 32'h5,         32'h0,         0, 1));
        vecs_a.push_back(mk(0, "byp_both", 12, 12, 1, 12, 32'hCAFE,      0,  0, 32'hCAFE,      32'hCAFE,      0, 0));
        vecs_a.push_back(mk(0, "top31",    31, 12, 1, 31, 32'h3131_3131, 0,  0, 32'h3131_3131, 32'hCAFE,      0, 0));
        vecs_a.push_back(mk(0, "rd31",     30, 31, 0,  0, 32'h0,         0,  0, 32'h0,         32'h3131_3131, 0, 0));
        vecs_a.push_back(mk(1, "nz_wr",     0,  0, 1,  0, 32'hFFFF_FFFF, 0,  0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0));
        vecs_a.push_back(mk(1, "nz_rsv",    0,  0, 0,  0, 32'h0,         1,  0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1));
        vecs_a.push_back(mk(1, "nz_clr",    0,  1, 1,  0, 32'h7,         0,  0, 32'h7,         32'h0,         0, 0));
        vecs_a.push_back(mk(2, "p_wr7",     7,  0, 1,  7, 32'hBEEF,      0,  0, 32'hBEEF,      32'h0,         0, 0));
        vecs_a.push_back(mk(2, "p_wr1",     1,  7, 1,  1, 32'h0001,      0,  0, 32'h0001,      32'hBEEF,      0, 0));
        vecs_a.push_back(mk(2, "p_rd01",    0,  1, 0,  0, 32'h0,         0,  0, 32'h0,         32'h0001,      0, 0));
        vecs_a.push_back(mk(2, "p_rd76",    7,  6, 0,  0, 32'h0,         0,  0, 32'hBEEF,      32'h0,         0, 0));
        vecs_a.push_back(mk(2, "p_noalias", 1,  7, 1,  0, 32'hFFFF,      0,  0, 32'h0001,      32'hBEEF,      0, 0));
        vecs_a.push_back(mk(0, "pre_wr3",   3,  0, 1,  3, 32'hA5A5_A5A5, 0,  0, 32'hA5A5_A5A5, 32'h0,         0, 0));
        vecs_a.push_back(mk(0, "pre_rsv4",  3,  4, 0,  0, 32'h0,         1,  4, 32'hA5A5_A5A5, 32'h0,         0, 1));

        vecs_b.push_back(mk(0, "post_rst",    3, 4, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0));
        vecs_b.push_back(mk(1, "post_rst_nz", 0, 0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0));
        vecs_b.push_back(mk(2, "post_rst_p",  7, 1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0));

        // Reset and sweep with writes hammering throughout.
        idle_all();
        #1 rst_n = 1'b0;
        #2;
        check("rst.ready",  {31'b0, bus0.ready}, 32'd0);
        check("rst.rd1",    bus0.readData1, 32'h0);
        check("rst.rd2",    bus0.readData2, 32'h0);
        check("rst.busy1",  {31'b0, bus0.busy1}, 32'd0);
        check("rst.ready2", {31'b0, bus2.ready}, 32'd0);
        bus0.write = 1'b1; bus0.writeReg = 5'd3; bus0.writeData = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_and_measure("sweep1", 1'b1);

        for (int i = 0; i < 32; i++) begin
            apply_vec(mk(0, $sformatf("clr%0d", i), 5'(i), 5'(31 - i), 0, 0, 32'h0, 0, 0,
                         32'h0, 32'h0, 0, 0));
        end

        foreach (vecs_a[i]) apply_vec(vecs_a[i]);

        // Asynchronous reset pulse inside the low phase of the clock.
        bus0.readReg1 = 5'd3; bus0.readReg2 = 5'd4;
        #2 rst_n = 1'b0;
        #1;
        check("midrst.rd1",   bus0.readData1, 32'h0);
        check("midrst.busy2", {31'b0, bus0.busy2}, 32'd0);
        check("midrst.ready", {31'b0, bus0.ready}, 32'd0);
        #1 rst_n = 1'b1;
        sweep_and_measure("sweep2", 1'b0);

        foreach (vecs_b[i]) apply_vec(vecs_b[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
